// File: rtl/jtag_user_data_register_if.sv
// DR-path bundle between the TAP/instruction decoder (master) and the
// user data register bank (slave).
interface jtag_user_data_register_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 4
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                        tdi;
  logic [SEL_W-1:0]            select;
  logic                        captureDR;
  logic                        shiftDR;
  logic                        updateDR;
  logic [NUM_REGS*WIDTH-1:0]   capture_data;
  logic                        tdo;
  logic [NUM_REGS*WIDTH-1:0]   update_data;
  logic [NUM_REGS-1:0]         update_valid;
  logic                        length_err;

  modport master (
    output tdi, select, captureDR, shiftDR, updateDR, capture_data,
    input  tdo, update_data, update_valid, length_err
  );

  modport slave (
    input  tdi, select, captureDR, shiftDR, updateDR, capture_data,
    output tdo, update_data, update_valid, length_err
  );
endinterface

// File: rtl/jtag_user_data_register.sv
// Multi-channel JTAG test data register bank: capture / LSB-first shift /
// shadowed update, with read-only channels and scan-length checking.
module jtag_user_data_register #(
  parameter int                          WIDTH            = 32,
  parameter int                          NUM_REGS         = 4,
  parameter logic [NUM_REGS-1:0]         RO_MASK          = 'b0001,
  parameter logic [NUM_REGS-1:0]         CAPTURE_EXT_MASK = 'b0011,
  parameter logic [NUM_REGS*WIDTH-1:0]   UPDATE_RESET     = '0
) (
  input  logic                       tck,
  input  logic                       trst,
  jtag_user_data_register_if.slave   bus
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic [WIDTH-1:0]                 shift_reg;
  logic [SEL_W-1:0]                 sel_q;
  logic [CNT_W-1:0]                 bit_cnt;
  logic [NUM_REGS-1:0][WIDTH-1:0]   upd_q;
  logic [NUM_REGS-1:0][WIDTH-1:0]   cap_in;
  logic [NUM_REGS-1:0]              upd_vld_q;
  logic                             len_err_q;
  logic [WIDTH-1:0]                 cap_val;
  logic [NUM_REGS-1:0]              wr_en;
  logic                             upd_act;
  logic                             len_ok;

  assign cap_in  = bus.capture_data;
  assign upd_act = bus.updateDR && !bus.captureDR && !bus.shiftDR;
  assign len_ok  = (bit_cnt == CNT_FULL);

  // Capture source: external slice or own latch; out-of-range select gives zeros
  always_comb begin
    cap_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.select == SEL_W'(i))
        cap_val = CAPTURE_EXT_MASK[i] ? cap_in[i] : upd_q[i];
  end

  // Per-channel write enable: correct length, matching sel_q, writable channel
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_en[i] = upd_act && len_ok && (sel_q == SEL_W'(i)) && !RO_MASK[i];
  end

  // Scan state and registered update/error strobes; capture > shift > update
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      shift_reg <= '0;
      sel_q     <= '0;
      bit_cnt   <= '0;
      upd_vld_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      upd_vld_q <= '0;
      len_err_q <= 1'b0;
      if (bus.captureDR) begin
        sel_q     <= bus.select;
        bit_cnt   <= '0;
        shift_reg <= cap_val;
      end else if (bus.shiftDR) begin
        shift_reg <= {bus.tdi, shift_reg[WIDTH-1:1]};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (bus.updateDR) begin
        upd_vld_q <= wr_en;
        len_err_q <= !len_ok;
      end
    end
  end

  // Shadow update latches, one per channel
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_latch
    always_ff @(posedge tck or negedge trst) begin
      if (!trst)         upd_q[g] <= UPDATE_RESET[g*WIDTH +: WIDTH];
      else if (wr_en[g]) upd_q[g] <= shift_reg;
    end
  end

  assign bus.tdo          = shift_reg[0];
  assign bus.update_data  = upd_q;
  assign bus.update_valid = upd_vld_q;
  assign bus.length_err   = len_err_q;
endmodule

// File: tb/tb_jtag_user_data_register.sv
// Directed bench for jtag_user_data_register with default parameters.
module tb_jtag_user_data_register;
  localparam int W = 32;
  localparam int N = 4;

  logic tck = 1'b0;
  logic tck_en = 1'b0;
  logic trst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [63:0] dout;

  jtag_user_data_register_if #(.WIDTH(W), .NUM_REGS(N)) bus ();

  jtag_user_data_register #(.WIDTH(W), .NUM_REGS(N)) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  always begin
    #5;
    if (tck_en) tck = ~tck;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one rising edge, then settle 1ns past it
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic capture(input logic [1:0] sel);
    bus.select = sel;
    bus.captureDR = 1'b1;
    tick();
    bus.captureDR = 1'b0;
  endtask

  // shift n bits of din LSB first, recording tdo before each edge
  task automatic scan(input logic [63:0] din, input int n, output logic [63:0] o);
    o = '0;
    for (int i = 0; i < n; i++) begin
      o[i % 64] = bus.tdo;
      bus.tdi = din[i % 64];
      bus.shiftDR = 1'b1;
      tick();
    end
    bus.shiftDR = 1'b0;
    bus.tdi = 1'b0;
  endtask

  task automatic update();
    bus.updateDR = 1'b1;
    tick();
    bus.updateDR = 1'b0;
  endtask

  initial begin
    logic [63:0] lo;
    logic [63:0] hi;
    bus.tdi = 1'b0;
    bus.select = '0;
    bus.captureDR = 1'b0;
    bus.shiftDR = 1'b0;
    bus.updateDR = 1'b0;
    bus.capture_data = '0;

    // reset with clock stopped
    #3 trst = 1'b0;
    #2;
    chk("rst_tdo", bus.tdo, 1'b0);
    chk("rst_data", bus.update_data, 128'h0);
    chk("rst_valid", bus.update_valid, 4'b0);
    chk("rst_err", bus.length_err, 1'b0);
    trst = 1'b1;
    #2 tck_en = 1'b1;
    tick();

    // IDCODE read; capture_data changed mid-scan must not matter
    bus.capture_data[31:0]  = 32'h1234_5679;
    bus.capture_data[63:32] = 32'hAAAA_5555;
    capture(2'd0);
    chk("id_tdo0", bus.tdo, 1'b1);
    scan(64'h0, 8, lo);
    chk("id_first8", lo[7:0], 8'h79);
    bus.capture_data[31:0] = 32'hFFFF_FFFF;
    scan(64'h0, 24, hi);
    chk("id_all32", {hi[23:0], lo[7:0]}, 32'h1234_5679);
    update();
    chk("id_valid", bus.update_valid, 4'b0);
    chk("id_err", bus.length_err, 1'b0);
    chk("id_latch0", bus.update_data[31:0], 32'h0);

    // write DEADBEEF into channel 2
    capture(2'd2);
    scan(64'hDEAD_BEEF, 32, dout);
    update();
    chk("wr_data", bus.update_data[95:64], 32'hDEAD_BEEF);
    chk("wr_valid", bus.update_valid, 4'b0100);
    chk("wr_err", bus.length_err, 1'b0);
    tick();
    chk("wr_valid_drop", bus.update_valid, 4'b0);

    // readback of channel 2, select moved to 3 mid-scan
    capture(2'd2);
    scan(64'hF00D, 16, lo);
    bus.select = 2'd3;
    scan(64'hCAFE, 16, hi);
    chk("rb_tdo", {hi[15:0], lo[15:0]}, 32'hDEAD_BEEF);
    update();
    chk("rb_latch2", bus.update_data[95:64], 32'hCAFE_F00D);
    chk("rb_latch3", bus.update_data[127:96], 32'h0);
    chk("rb_valid", bus.update_valid, 4'b0100);

    // bad length: 31 then 40 shifts into channel 3
    capture(2'd3);
    scan(64'hFFFF_FFFF_FFFF_FFFF, 31, dout);
    update();
    chk("len31_err", bus.length_err, 1'b1);
    chk("len31_valid", bus.update_valid, 4'b0);
    chk("len31_latch3", bus.update_data[127:96], 32'h0);
    tick();
    chk("len31_err_drop", bus.length_err, 1'b0);
    capture(2'd3);
    scan(64'hFFFF_FFFF_FFFF_FFFF, 40, dout);
    update();
    chk("len40_err", bus.length_err, 1'b1);
    chk("len40_latch3", bus.update_data[127:96], 32'h0);
    update();
    chk("len40_repeat_err", bus.length_err, 1'b1);
    // read-only channel with wrong length still reports an error
    capture(2'd0);
    scan(64'h0, 5, dout);
    update();
    chk("ro_len_err", bus.length_err, 1'b1);

    // capture and update together: capture wins, no strobes
    capture(2'd2);
    scan(64'h1111_1111, 32, dout);
    bus.select = 2'd2;
    bus.captureDR = 1'b1;
    bus.updateDR = 1'b1;
    tick();
    bus.captureDR = 1'b0;
    bus.updateDR = 1'b0;
    chk("both_valid", bus.update_valid, 4'b0);
    chk("both_err", bus.length_err, 1'b0);
    chk("both_latch2", bus.update_data[95:64], 32'hCAFE_F00D);
    chk("both_tdo", bus.tdo, 1'b1);

    // reset mid-scan
    capture(2'd2);
    scan(64'h0, 10, dout);
    trst = 1'b0;
    #2;
    chk("mid_rst_tdo", bus.tdo, 1'b0);
    chk("mid_rst_latch2", bus.update_data[95:64], 32'h0);
    trst = 1'b1;
    tick();
    update();
    chk("post_rst_err", bus.length_err, 1'b1);
    chk("post_rst_data", bus.update_data, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jtag_user_data_register.md
# jtag_user_data_register

Parametrised, multi-channel JTAG test data register bank: the generalised successor to the fixed 32-bit device-identification register. It sits behind the TAP controller's DR path and provides NUM_REGS selectable WIDTH-bit registers, each with capture, serial shift, and a shadowed update latch. Read-only channels, such as IDCODE, are supported, and scans of the wrong length are rejected. The TAP drives the control strobes; the instruction decoder drives `select`.

## Interface
- `WIDTH`, 32: bits per data register (≥2).
- `NUM_REGS`, 4: number of selectable registers (≥1); `SEL_W = max(1, $clog2(NUM_REGS))`.
- `RO_MASK`, 'b0001: bit i = 1 means register i is read-only; updates are ignored.
- `CAPTURE_EXT_MASK`, 'b0011: bit i = 1 means capture loads `capture_data` slice i; 0 means capture loads register i's own update latch (readback).
- `UPDATE_RESET`, all zeros: `NUM_REGS*WIDTH` flattened reset value of the update latches; slice i is `[i*WIDTH +: WIDTH]`.

Ports:
- `tck` input 1: the only clock; all state changes on its rising edge.
- `trst` input 1: asynchronous, active-low reset.
- `tdi` input 1: serial data in.
- `select` input SEL_W: register index from the instruction decoder.
- `captureDR` input 1: capture strobe.
- `shiftDR` input 1: shift strobe.
- `updateDR` input 1: update strobe.
- `capture_data` input NUM_REGS*WIDTH: parallel capture values; slice i belongs to register i.
- `tdo` output 1: serial data out, equal to `shift_reg[0]`.
- `update_data` output NUM_REGS*WIDTH: update latch contents.
- `update_valid` output NUM_REGS: one-cycle strobe per register on a successful update.
- `length_err` output 1: one-cycle pulse when an update is rejected for a bit count ≠ WIDTH.

## Operation
- State:
  - `shift_reg[WIDTH-1:0]`
  - `sel_q[SEL_W-1:0]`
  - `bit_cnt`, saturating at WIDTH+1, width `$clog2(WIDTH+2)`
  - NUM_REGS update latches
- Strobe priority when several are high in one cycle: captureDR > shiftDR > updateDR. Only the highest-priority strobe acts.
- **Capture.**
  - `sel_q <= select`; `bit_cnt <= 0`.
  - `shift_reg` loads `capture_data` slice or latch readback, per CAPTURE_EXT_MASK[select].
  - If `select ≥ NUM_REGS`, `shift_reg` loads all zeros.
- **Shift.**
  - `shift_reg <= {tdi, shift_reg[WIDTH-1:1]}`, LSB out first.
  - `bit_cnt` increments and saturates at WIDTH+1.
  - `select` is ignored. Only `sel_q` governs the scan.
- **Update.**
  - If `bit_cnt == WIDTH`, `sel_q < NUM_REGS` and `!RO_MASK[sel_q]`: latch `sel_q` loads `shift_reg`, and `update_valid[sel_q]` is high the next cycle.
  - If `bit_cnt != WIDTH`: no latch changes, and `length_err` is high the next cycle. This applies to every `sel_q`, including read-only registers.
  - A read-only register or invalid `sel_q` with a correct count: no action, no error.
  - `bit_cnt` is unchanged by an update, so a repeated update repeats the same result.
- No strobe: all state holds. `update_valid` and `length_err` return to 0.

## Timing
- Reset (`trst` low), immediate and asynchronous:
  - `shift_reg = 0`, so `tdo = 0`
  - `sel_q = 0`
  - `bit_cnt = 0`
  - `update_data = UPDATE_RESET`
  - `update_valid = 0`
  - `length_err = 0`
- Reset asserted mid-scan aborts the scan. No partial update ever reaches a latch.
- Capture edge to `tdo`: `tdo` shows bit 0 of the captured value right after the capture edge. Each shift edge presents the next bit.
- A full scan is 1 capture edge, WIDTH shift edges, then 1 update edge.
- Update edge: `update_data` changes on that edge. `update_valid` / `length_err` are registered, high for exactly the one cycle after that edge, and never high for 2 consecutive cycles unless `updateDR` is held.
- A `capture_data` change after the capture edge has no effect on the scan in progress.

## Test plan
Defaults: WIDTH=32, NUM_REGS=4, RO_MASK=0001, CAPTURE_EXT_MASK=0011.

- **Reset:** `trst` low with `tck` stopped → `tdo` = 0, `update_data` = 0, `update_valid` = 0, `length_err` = 0.
- **IDCODE read:** `select` = 0, `capture_data[31:0]` = 32'h1234_5679; capture then 32 shifts → `tdo` gives 1,0,0,1,1,1,1,0,… (LSB first, 32 bits). A following update → no `update_valid`, no `length_err`, latch 0 unchanged.
- **Write:** `select` = 2, capture, shift 32'hDEAD_BEEF in LSB first, update → `update_data[95:64]` = DEADBEEF; `update_valid` = 4'b0100 for 1 cycle.
- **Readback:** `select` = 2, capture, 32 shifts → `tdo` serialises DEADBEEF LSB first. Change `select` to 3 mid-scan, then update → only latch 2 is written.
- **Bad length:** `select` = 3, capture, 31 shifts, update → `length_err` pulses 1 cycle, latch 3 unchanged. Repeat with 40 shifts → same result.
- **Reset mid-scan, plus simultaneous strobes:**
  - After the write above, capture, 10 shifts, then `trst` low → `tdo` = 0 at once and latch 2 returns to 0.
  - `captureDR` and `updateDR` high together → only the capture occurs, no strobes.
